dmi_req_arbiter: RTL and testbench
==================================

// Module: dmi_req_arbiter
// PURPOSE
//  Shares one 32-bit valid/ready request channel between NUM_REQ requesters
//  (e.g. JTAG DTM, on-chip debug agent). That channel feeds the register-slice
//  synchroniser stage.
//  - Round-robin arbitration; one transaction in flight at a time.
//  - Response from the slice is routed back to the granted requester only.
//  - A watchdog completes a hung transaction with an error response.
// PARAMETERS
//  NUM_REQ   2    number of requesters (2..8)
//  DATA_W    32   request/response payload width
//  TIMEOUT   255  WAIT_RSP cycles before forced error response (1..65535)
// PORTS
//  clk_i        in   1              clock
//  rst_ni       in   1              async reset, active low
//  req_valid_i  in   NUM_REQ        per-requester request valid
//  req_ready_o  out  NUM_REQ        per-requester accept strobe (one-hot or 0)
//  req_data_i   in   NUM_REQ*DATA_W requester k payload at [k*DATA_W +: DATA_W]
//  valid_o      out  1              request valid toward sync stage
//  ready_i      in   1              sync stage accepts request
//  data_o       out  DATA_W         request payload toward sync stage
//  rsp_valid_i  in   1              response valid from sync stage
//  rsp_data_i   in   DATA_W         response payload from sync stage
//  rsp_valid_o  out  NUM_REQ        one-cycle response pulse, one-hot to owner
//  rsp_data_o   out  DATA_W         response payload (shared bus)
//  rsp_err_o    out  1              qualifies rsp_valid_o: 1 = timeout
//  stray_o      out  1              one-cycle pulse: response with nothing in flight
//  busy_o       out  1              state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; all outputs 0; data_o and rsp_data_o are 0.
//   - RR pointer = NUM_REQ-1, so requester 0 wins first.
//   - Watchdog counter = 0.
//  FSM IDLE -> ISSUE -> WAIT_RSP -> IDLE:
//   IDLE
//    - If any req_valid_i: winner = first set bit searching from ptr+1 upward,
//      with wrap.
//    - req_ready_o[winner]=1 combinationally that cycle.
//    - Latch req_data_i slice into data_o; owner <= winner; go ISSUE.
//    - No request: stay in IDLE; req_ready_o=0.
//   ISSUE
//    - valid_o=1; data_o held stable until ready_i.
//    - On ready_i: go WAIT_RSP; counter <= 0.
//    - No timeout in ISSUE; the sync stage is always eventually ready.
//   WAIT_RSP
//    - valid_o=0; counter increments each cycle.
//    - On rsp_valid_i, next cycle:
//      rsp_valid_o[owner]=1, rsp_data_o=rsp_data_i, rsp_err_o=0.
//      ptr <= owner; go IDLE.
//    - Else if counter==TIMEOUT-1, next cycle:
//      rsp_valid_o[owner]=1, rsp_data_o=0, rsp_err_o=1.
//      ptr <= owner; go IDLE.
//    - rsp_valid_i and timeout in the same cycle: the real response wins, err=0.
//  Timing and latency:
//   - rsp_valid_o, rsp_data_o, rsp_err_o, valid_o, data_o, stray_o are registered.
//   - Accept-to-valid_o latency is 1 cycle.
//   - Response-in to rsp_valid_o latency is 1 cycle.
//   - Minimum turnaround is 4 cycles: accept, issue, rsp in, rsp out;
//     the next grant can occur in the cycle rsp_valid_o is high.
//  Other rules:
//   - req_ready_o is never asserted outside IDLE; requesters hold valid+data
//     until accepted.
//   - rsp_valid_i outside WAIT_RSP: dropped; stray_o=1 next cycle; FSM unaffected.
//   - A response arriving after a timeout is likewise stray.
//   - Fairness: a requester continuously valid waits at most NUM_REQ-1
//     transactions.
//   - Reset asserted mid-transaction aborts it: no rsp_valid_o is produced.
//     Any later response is stray.
// TESTING
//  1 Reset: hold rst_ni=0 while toggling all inputs
//    -> all outputs 0, busy_o=0.
//    Release, then req_valid_i=2'b11
//    -> req_ready_o=2'b01 in the first cycle.
//  2 Single txn: req0 data 0xDEADBEEF
//    -> valid_o=1 next cycle with data_o=0xDEADBEEF.
//    ready_i after 3 cycles; rsp_valid_i with 0x12345678
//    -> rsp_valid_o=2'b01, rsp_data_o=0x12345678, err=0, 1 cycle later.
//  3 Round-robin: both requesters valid for 4 txns
//    -> grants 0,1,0,1.
//    Req1 alone after a req1 grant -> req1 granted again (no idle gap).
//  4 Timeout: TIMEOUT=8, never send rsp
//    -> rsp_valid_o[owner]=1, rsp_err_o=1, rsp_data_o=0, 9 cycles after ready_i.
//    Response sent afterwards -> stray_o pulse, state IDLE.
//  5 Tie: rsp_valid_i on the exact timeout cycle
//    -> err=0, data passed through.
//    rsp_valid_i while IDLE -> stray_o=1 for one cycle.
//  6 Mid-op reset: assert rst_ni in WAIT_RSP
//    -> no rsp_valid_o, ptr reset.
//    First post-reset grant goes to requester 0.

Source files
------------

// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter
//   Shares one valid/ready request channel toward the register-slice
//   synchroniser between NUM_REQ requesters. Round-robin arbitration with a
//   single transaction in flight; the response is routed back to the granted
//   requester only, and a watchdog completes a hung transaction with an error.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active low
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester accept strobe (one-hot or zero, IDLE only)
//   req_data_i   requester k payload at [k*DATA_W +: DATA_W]
//   valid_o      request valid toward sync stage (registered)
//   ready_i      sync stage accepts request
//   data_o       request payload toward sync stage (registered)
//   rsp_valid_i  response valid from sync stage
//   rsp_data_i   response payload from sync stage
//   rsp_valid_o  one-cycle response pulse, one-hot to owner (registered)
//   rsp_data_o   response payload, shared bus (registered)
//   rsp_err_o    qualifies rsp_valid_o: 1 = watchdog timeout (registered)
//   stray_o      one-cycle pulse: response arrived with nothing awaiting it
//   busy_o       FSM not idle
module dmi_req_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_W-1:0]         data_o,
    input  logic                      rsp_valid_i,
    input  logic [DATA_W-1:0]         rsp_data_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      stray_o,
    output logic                      busy_o
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] TimeoutM1 = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    state_e              state_q;
    logic [PtrW-1:0]     ptr_q;
    logic [PtrW-1:0]     owner_q;
    logic [CntW-1:0]     cnt_q;
    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic                stray_q;

    logic                grant_found;
    logic [PtrW-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;

    // Round-robin pick: first valid strictly above ptr_q, then wrap to the
    // lowest valid at or below ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && req_valid_i[j] && (PtrW'(j) > ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = PtrW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && req_valid_i[j] && (PtrW'(j) <= ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = PtrW'(j);
            end
        end
        grant_data = req_data_i[grant_idx*DATA_W +: DATA_W];
    end

    // Accept strobe is combinational; rst_ni gating keeps it quiet while the
    // block is held in reset even though the state already reads IDLE.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && (state_q == StIdle) && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= PtrW'(NUM_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            // Response strobes are single-cycle pulses.
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            stray_q     <= rsp_valid_i && (state_q != StWaitRsp);

            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        data_q  <= grant_data;
                        owner_q <= grant_idx;
                        valid_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    cnt_q <= cnt_q + CntW'(1);
                    // A real response beats a coincident timeout.
                    if (rsp_valid_i) begin
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_data_q           <= rsp_data_i;
                        ptr_q                <= owner_q;
                        state_q              <= StIdle;
                    end else if (cnt_q == TimeoutM1) begin
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_data_q           <= '0;
                        rsp_err_q            <= 1'b1;
                        ptr_q                <= owner_q;
                        state_q              <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign stray_o     = stray_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Testbench for dmi_req_arbiter (NUM_REQ=2, DATA_W=32, TIMEOUT=8).
// Stimulus pushes expected grants, requests, responses and stray pulses into
// queues, each tagged with the cycle it must appear in; a negedge monitor pops
// and compares whenever the DUT presents the corresponding output.
module tb_dmi_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        stray_o;
    logic        busy_o;

    dmi_req_arbiter #(
        .NUM_REQ (2),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_data_i  (rsp_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .stray_o     (stray_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } req_exp_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    int       exp_grant_q[$];
    req_exp_t exp_req_q[$];
    rsp_exp_t exp_rsp_q[$];
    int       exp_stray_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic        valid_prev = 1'b0;
    logic [31:0] data_held  = '0;

    always @(negedge clk) begin
        if (!rst_ni) begin
            valid_prev = 1'b0;
        end else begin
            if (req_ready_o != 2'b00) begin
                if (exp_grant_q.size() == 0) begin
                    chk("grant_unexpected", {62'd0, req_ready_o}, 64'd0);
                end else begin
                    int w;
                    w = exp_grant_q.pop_front();
                    chk("grant", {62'd0, req_ready_o}, 64'd1 << w);
                    chk("grant_only_idle", {63'd0, busy_o}, 64'd0);
                end
            end
            if (valid_o && !valid_prev) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", {63'd0, valid_o}, 64'd0);
                end else begin
                    req_exp_t e;
                    e = exp_req_q.pop_front();
                    chk("req_data", {32'd0, data_o}, {32'd0, e.data});
                    chk("req_cycle", 64'(cyc), 64'(e.cyc));
                end
                data_held = data_o;
            end else if (valid_o && valid_prev) begin
                chk("req_data_stable", {32'd0, data_o}, {32'd0, data_held});
            end
            valid_prev = valid_o;

            if (rsp_valid_o != 2'b00) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {62'd0, rsp_valid_o}, 64'd0);
                end else begin
                    rsp_exp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_owner", {62'd0, rsp_valid_o}, 64'd1 << r.owner);
                    chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, r.data});
                    chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, r.err});
                    chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (stray_o) begin
                if (exp_stray_q.size() == 0) begin
                    chk("stray_unexpected", {63'd0, stray_o}, 64'd0);
                end else begin
                    int sc;
                    sc = exp_stray_q.pop_front();
                    chk("stray_cycle", 64'(cyc), 64'(sc));
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; the grant is expected this cycle.
    task automatic issue(input logic [1:0] mask, input int win,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_exp_t e;
        req_valid_i = mask;
        req_data_i  = {d1, d0};
        exp_grant_q.push_back(win);
        e.data = (win == 1) ? d1 : d0;
        e.cyc  = cyc + 1;
        exp_req_q.push_back(e);
        tick();
        req_valid_i = 2'b00;
    endtask

    task automatic handshake(input int dly, output int rdy_cyc);
        repeat (dly) tick();
        ready_i = 1'b1;
        rdy_cyc = cyc;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [31:0] d, input int owner);
        rsp_exp_t r;
        repeat (dly) tick();
        rsp_valid_i = 1'b1;
        rsp_data_i  = d;
        r.owner = owner;
        r.data  = d;
        r.err   = 1'b0;
        r.cyc   = cyc + 1;
        exp_rsp_q.push_back(r);
        tick();
        rsp_valid_i = 1'b0;
    endtask

    task automatic stray_rsp(input logic [31:0] d);
        rsp_valid_i = 1'b1;
        rsp_data_i  = d;
        exp_stray_q.push_back(cyc + 1);
        tick();
        rsp_valid_i = 1'b0;
    endtask

    logic [1:0] rr_mask [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    int         rr_win  [6] = '{1, 0, 1, 0, 1, 1};

    initial begin
        int       r;
        rsp_exp_t te;

        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        ready_i     = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_data_i  = '0;

        // 1: outputs stay quiet in reset whatever the inputs do.
        repeat (5) begin
            tick();
            req_valid_i = 2'($urandom);
            req_data_i  = {$urandom, $urandom};
            ready_i     = 1'($urandom);
            rsp_valid_i = 1'($urandom);
            rsp_data_i  = $urandom;
            @(negedge clk);
            chk("rst_ctrl", {56'd0, req_ready_o, valid_o, rsp_valid_o, rsp_err_o, stray_o, busy_o},
                64'd0);
            chk("rst_data", {data_o, rsp_data_o}, 64'd0);
        end
        tick();
        req_valid_i = '0;
        ready_i     = 1'b0;
        rsp_valid_i = 1'b0;
        rst_ni      = 1'b1;

        // 1+2: both valid out of reset -> requester 0; single transaction.
        issue(2'b11, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        handshake(3, r);
        respond(0, 32'h1234_5678, 0);

        // 3: round-robin, back-to-back with the response cycle.
        for (int i = 0; i < 6; i++) begin
            issue(rr_mask[i], rr_win[i], 32'h1000_0000 + i, 32'h2000_0000 + i);
            handshake(0, r);
            respond(1, 32'h3000_0000 + i, rr_win[i]);
        end

        // 4: timeout for requester 0, then a late response is stray.
        issue(2'b01, 0, 32'h4444_0000, 32'h0);
        handshake(1, r);
        te.owner = 0;
        te.data  = 32'h0;
        te.err   = 1'b1;
        te.cyc   = r + 9;
        exp_rsp_q.push_back(te);
        repeat (9) tick();
        stray_rsp(32'hBAD0_0001);
        chk("idle_after_timeout", {63'd0, busy_o}, 64'd0);

        // 5: response on the timeout cycle wins; then a response while idle.
        issue(2'b10, 1, 32'h0, 32'h5555_0000);
        handshake(0, r);
        respond(7, 32'hA5A5_5A5A, 1);
        stray_rsp(32'hBAD0_0002);

        // 6: leave ptr at 0, then reset in WAIT_RSP.
        issue(2'b01, 0, 32'h6666_0000, 32'h0);
        handshake(0, r);
        respond(0, 32'h6666_1111, 0);
        issue(2'b01, 0, 32'h7777_0000, 32'h0);
        handshake(0, r);
        repeat (2) tick();
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        chk("midrst_rsp", {62'd0, rsp_valid_o}, 64'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        stray_rsp(32'hBAD0_0003);
        tick();
        issue(2'b11, 0, 32'h8888_0000, 32'h9999_0000);
        handshake(0, r);
        respond(2, 32'h8888_1111, 0);
        repeat (4) tick();

        chk("grants_left", 64'(exp_grant_q.size()), 64'd0);
        chk("reqs_left", 64'(exp_req_q.size()), 64'd0);
        chk("rsps_left", 64'(exp_rsp_q.size()), 64'd0);
        chk("strays_left", 64'(exp_stray_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
